vedic_mult_pipe: RTL and testbench
==================================

// Module: vedic_mult_pipe
// PURPOSE
//  Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier. Successor to the fixed 4x4 combinational multiplier.
//  - Operands: WIDTH x WIDTH bits. Mode per transaction: unsigned or two's-complement signed.
//  - Handshakes: valid/ready on input and output, so the block sits between a stream source and a sink that may stall.
//  - Throughput: one product per cycle when not stalled.
// PARAMETERS
//  WIDTH   8  operand width; power of two, >= 4
//  TAG_W   4  width of the opaque tag carried alongside each operand pair; >= 1
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        reset, asynchronous assert, active-low
//  in_valid   in   1        operand pair present
//  in_ready   out  1        block accepts in this cycle
//  in_a       in   WIDTH    multiplicand
//  in_b       in   WIDTH    multiplier
//  in_signed  in   1        1 = two's-complement operands, 0 = unsigned
//  in_tag     in   TAG_W    user tag, returned unchanged with the product
//  out_valid  out  1        product present
//  out_ready  in   1        sink accepts in this cycle
//  out_p      out  2*WIDTH  product; signed or unsigned per the captured in_signed
//  out_tag    out  TAG_W    tag of this product
//  busy       out  1        any pipeline stage holds a valid entry
// BEHAVIOUR
//  Reset (rst_n low, async)
//  - All stage valid bits, data registers, out_valid, out_p, out_tag and busy go to 0 immediately. in_ready = 1 after reset.
//  Pipeline
//  - L = log2(WIDTH) register stages. WIDTH=8 gives L=3; WIDTH=4 gives L=2.
//  - Stage 1: the input register. Captures magnitudes |a| and |b| when in_signed=1, raw operands otherwise. Also captures the result sign (a_msb ^ b_msb) & in_signed, and the tag. Forms all 2x2 Vedic partial products.
//  - Stage k (2..L): combines four half-width products: P = p_ll + (p_hl << h) + (p_lh << h) + (p_hh << 2h), where h is the sub-operand width at that level. Full carry is kept; no truncation until 2*WIDTH bits.
//  - Stage L: the output register. Takes the two's-complement negation of the combined magnitude when the sign bit is set, before registering.
//  Magnitude width
//  - |a| is held in WIDTH bits unsigned, so -2^(WIDTH-1) is exact.
//  - Example, WIDTH=8: 8'h80 * 8'h80 signed = 16'h4000.
//  Handshake
//  - Global advance: adv = !out_valid || out_ready. in_ready = adv.
//  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - When adv=0 every stage holds. out_p and out_tag must stay stable while out_valid=1 and out_ready=0.
//  - Latency: L cycles from input transfer to out_valid, with no stalls.
//  - Bubbles travel with the pipeline; they do not collapse.
//  - Order is strictly preserved. No transfer is ever dropped or duplicated.
//  - In/out transfers in the same cycle are legal and do not disturb throughput.
//  Inputs
//  - in_a, in_b, in_signed and in_tag are ignored when in_valid=0 or in_ready=0.
//  - Invalid stages may hold stale data; out_p is only meaningful when out_valid=1.
//  - busy = OR of all stage valid bits.
//  Reset mid-operation
//  - In-flight entries are discarded. No out_valid pulse is generated for them after rst_n rises.
// STRUCTURE
//  Shared package vedic_pkg
//  - clog2 function.
//  - Localparam derivation L = clog2(WIDTH).
//  - Product combine function vedic_combine(p_ll, p_hl, p_lh, p_hh, h).
//  Sub-module vedic_2x2
//  - 2-bit x 2-bit partial-product cell, purely combinational.
//  - Instantiated (WIDTH/2)^2 times in stage 1 via generate.
//  Top level
//  - Stages 2..L generated in a loop over levels, each with a valid bit and a data array.
// TESTING  (WIDTH=8, TAG_W=4 unless noted)
//  1. Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, busy=0, out_p=0. After release, in_ready=1.
//  2. Unsigned: a=8'hFF, b=8'hFF, tag=4'hA -> exactly 3 cycles later out_valid=1, out_p=16'hFE01, out_tag=4'hA.
//  3. Signed corners:
//     - 8'h80*8'h80 -> 16'h4000
//     - 8'hFF*8'h01 -> 16'hFFFF
//     - 8'h7F*8'h80 -> 16'hC080
//     - same 8'hFF*8'h01 unsigned -> 16'h00FF
//  4. Back-pressure: stream 5 ops back-to-back, drop out_ready for 4 cycles mid-stream.
//     -> in_ready=0 while the output is held, out_p stable, all 5 results in order with correct tags.
//  5. Reset mid-flight: 2 ops in pipe, pulse rst_n low for 1 cycle.
//     -> busy=0 at once; no out_valid afterwards until new input.
//  6. WIDTH=4, exhaustive 256x2 modes with random in_valid/out_ready against a behavioural a*b model.
//     -> zero mismatches, latency 2 when unstalled.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared helpers for the pipelined Vedic multiplier: a constant log2 and the
// four-way partial-product combine used at every level above the 2x2 cells.
package vedic_pkg;

  // Working width for the combine arithmetic; supports WIDTH up to 32.
  localparam int unsigned VW = 64;
  localparam int unsigned MAX_WIDTH = VW / 2;

  typedef logic [VW-1:0] vword_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  // Urdhva-Tiryagbhyam combine of four half-width products, h = half width.
  function automatic vword_t vedic_combine(input vword_t p_ll, input vword_t p_hl,
                                           input vword_t p_lh, input vword_t p_hh,
                                           input int unsigned h);
    return p_ll + (p_hl << h) + (p_lh << h) + (p_hh << (2 * h));
  endfunction

endpackage

// File: rtl/vedic_2x2.sv
// 2-bit x 2-bit Vedic partial-product cell, purely combinational.
module vedic_2x2
  import vedic_pkg::*;
(
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);

  logic w_x10;
  logic w_x01;
  logic w_cross_s;
  logic w_cross_c;
  logic w_vert_hi;

  // Crosswise step: a1*b0 + a0*b1, vertical step: a1*b1 plus cross carry.
  assign w_x10     = i_a[1] & i_b[0];
  assign w_x01     = i_a[0] & i_b[1];
  assign w_cross_s = w_x10 ^ w_x01;
  assign w_cross_c = w_x10 & w_x01;
  assign w_vert_hi = i_a[1] & i_b[1];

  assign o_p = {w_vert_hi & w_cross_c, w_vert_hi ^ w_cross_c, w_cross_s, i_a[0] & i_b[0]};

endmodule

// File: rtl/vedic_mult_pipe.sv
// Pipelined WIDTH x WIDTH Vedic multiplier with valid/ready on both sides.
// Stage 1 registers operand magnitudes, result sign and tag; each further
// stage merges four half-width products into one of double width. The last
// stage applies the sign and is the output register. All stages advance
// together whenever the output is empty or being taken.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int unsigned L  = clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  logic             w_adv;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic [L-1:0]     r_vld;
  logic [L-2:0]     r_sgn;
  logic [TAG_W-1:0] r_tag [L];

  assign w_adv     = !r_vld[L-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[L-1];
  assign out_tag   = r_tag[L-1];
  assign busy      = |r_vld;

  // Magnitudes stay WIDTH bits unsigned, so the most negative value is exact.
  assign w_mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign w_mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

  // Input capture plus valid/sign/tag sideband shifting with the data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_sgn   <= '0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      for (int unsigned i = 0; i < L; i++) r_tag[i] <= '0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_mag_a  <= w_mag_a;
        r_mag_b  <= w_mag_b;
        r_sgn[0] <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        r_tag[0] <= in_tag;
      end
      for (int unsigned i = 1; i < L; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      for (int unsigned i = 1; i < L - 1; i++) r_sgn[i] <= r_sgn[i-1];
    end
  end

  // Level k holds (WIDTH>>k)^2 products of 2^k-bit operand segments; entry
  // index is a_segment * NS + b_segment.
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned NS = WIDTH >> k;
    logic [PW-1:0] w_prod [NS*NS];

    if (k == 1) begin : g_cells
      for (genvar i = 0; i < NS; i++) begin : g_a
        for (genvar j = 0; j < NS; j++) begin : g_b
          logic [3:0] w_pp;
          vedic_2x2 u_cell (
            .i_a (r_mag_a[2*i +: 2]),
            .i_b (r_mag_b[2*j +: 2]),
            .o_p (w_pp)
          );
          assign w_prod[i*NS + j] = PW'(w_pp);
        end
      end
    end else begin : g_stage
      for (genvar i = 0; i < NS; i++) begin : g_a
        for (genvar j = 0; j < NS; j++) begin : g_b
          localparam int unsigned PNS  = 2 * NS;
          localparam int unsigned BASE = (2 * i) * PNS + (2 * j);
          logic [PW-1:0] w_mag;
          logic [PW-1:0] w_nxt;
          logic [PW-1:0] r_p;

          assign w_mag = PW'(vedic_combine(
                           vword_t'(g_lvl[k-1].w_prod[BASE]),
                           vword_t'(g_lvl[k-1].w_prod[BASE + PNS]),
                           vword_t'(g_lvl[k-1].w_prod[BASE + 1]),
                           vword_t'(g_lvl[k-1].w_prod[BASE + PNS + 1]),
                           32'd1 << (k - 1)));
          // Only the final level applies the sign carried from stage 1.
          assign w_nxt = (k == L && r_sgn[k-2]) ? -w_mag : w_mag;

          // Product register for this level; holds while the output stalls.
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_p <= '0;
            else if (w_adv) r_p <= w_nxt;
          end

          assign w_prod[i*NS + j] = r_p;
        end
      end
    end
  end

  assign out_p = g_lvl[L].w_prod[0];

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe: an 8-bit instance for directed cases and a
// 4-bit instance swept exhaustively under random valid/ready.
module tb_vedic_mult_pipe;

  typedef struct packed { logic [15:0] p; logic [3:0] tag; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_p;

  logic        u4_in_valid, u4_in_ready, u4_in_signed, u4_out_valid, u4_out_ready, u4_busy;
  logic [3:0]  u4_in_a, u4_in_b, u4_in_tag, u4_out_tag;
  logic [7:0]  u4_out_p;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_out8 = 0;
  int unsigned n_out4 = 0;
  exp_t q8[$];
  exp_t q4[$];
  logic hold8 = 1'b0, hold4 = 1'b0;
  logic [15:0] held_p8;
  logic [7:0]  held_p4;
  logic [3:0]  held_t8, held_t4;
  logic w4_done = 1'b0;

  always #5 clk = ~clk;

  vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_tag(out_tag), .busy(busy)
  );

  vedic_mult_pipe #(.WIDTH(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(u4_in_valid), .in_ready(u4_in_ready),
    .in_a(u4_in_a), .in_b(u4_in_b), .in_signed(u4_in_signed), .in_tag(u4_in_tag),
    .out_valid(u4_out_valid), .out_ready(u4_out_ready), .out_p(u4_out_p),
    .out_tag(u4_out_tag), .busy(u4_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference product: plain integer multiply of the interpreted operands.
  function automatic logic [15:0] model(input int unsigned w, input logic [7:0] a,
                                        input logic [7:0] b, input logic s);
    longint va, vb, p;
    va = longint'(a);
    vb = longint'(b);
    if (s && va >= (64'sd1 <<< (w - 1))) va = va - (64'sd1 <<< w);
    if (s && vb >= (64'sd1 <<< (w - 1))) vb = vb - (64'sd1 <<< w);
    p = va * vb;
    return 16'(p & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  // Scoreboard compare on every falling edge for both instances.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q8.delete(); q4.delete();
      hold8 = 1'b0; hold4 = 1'b0;
    end else begin
      chk("busy8", 32'(busy), 32'(q8.size() != 0));
      chk("rdy8", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold8) begin
        chk("hold_v8", 32'(out_valid), 32'd1);
        chk("hold_p8", 32'(out_p), 32'(held_p8));
        chk("hold_t8", 32'(out_tag), 32'(held_t8));
      end
      if (out_valid && q8.size() == 0) chk("spurious8", 32'(out_valid), 32'd0);
      else if (out_valid && out_ready) begin
        e = q8.pop_front();
        chk("p8", 32'(out_p), 32'(e.p));
        chk("tag8", 32'(out_tag), 32'(e.tag));
        n_out8++;
      end
      hold8 = out_valid && !out_ready; held_p8 = out_p; held_t8 = out_tag;
      if (in_valid && in_ready) q8.push_back('{p: model(8, in_a, in_b, in_signed), tag: in_tag});

      chk("busy4", 32'(u4_busy), 32'(q4.size() != 0));
      chk("rdy4", 32'(u4_in_ready), 32'(!u4_out_valid || u4_out_ready));
      if (hold4) begin
        chk("hold_v4", 32'(u4_out_valid), 32'd1);
        chk("hold_p4", 32'(u4_out_p), 32'(held_p4));
        chk("hold_t4", 32'(u4_out_tag), 32'(held_t4));
      end
      if (u4_out_valid && q4.size() == 0) chk("spurious4", 32'(u4_out_valid), 32'd0);
      else if (u4_out_valid && u4_out_ready) begin
        e = q4.pop_front();
        chk("p4", 32'(u4_out_p), 32'(e.p));
        chk("tag4", 32'(u4_out_tag), 32'(e.tag));
        n_out4++;
      end
      hold4 = u4_out_valid && !u4_out_ready; held_p4 = u4_out_p; held_t4 = u4_out_tag;
      if (u4_in_valid && u4_in_ready)
        q4.push_back('{p: model(4, {4'b0, u4_in_a}, {4'b0, u4_in_b}, u4_in_signed), tag: u4_in_tag});
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] t);
    int unsigned k;
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) chk("send8_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic one8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [3:0] t, input logic [15:0] exp_p, input string nm);
    int unsigned k;
    send8(a, b, s, t);
    in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 10) begin @(negedge clk); k++; end
    chk(nm, 32'(out_p), 32'(exp_p));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, seq;
    logic acc;
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_signed = 1'b0; in_tag = 4'h0; out_ready = 1'b1;
    u4_in_valid = 1'b0; u4_in_a = '0; u4_in_b = '0; u4_in_signed = 1'b0; u4_in_tag = '0; u4_out_ready = 1'b1;

    // Reset held with in_valid asserted.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Unsigned FF*FF, latency exactly 3.
    send8(8'hFF, 8'hFF, 1'b0, 4'hA);
    in_valid = 1'b0;
    @(negedge clk); chk("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_c2", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_c3", 32'(out_valid), 32'd1);
    chk("ff_ff_p", 32'(out_p), 32'h0000_FE01);
    chk("ff_ff_tag", 32'(out_tag), 32'h0000_000A);
    @(posedge clk); #1;

    // Signed corners and an unsigned counterpart.
    one8(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000, "s_80_80");
    one8(8'hFF, 8'h01, 1'b1, 4'h2, 16'hFFFF, "s_ff_01");
    one8(8'h7F, 8'h80, 1'b1, 4'h3, 16'hC080, "s_7f_80");
    one8(8'hFF, 8'h01, 1'b0, 4'h4, 16'h00FF, "u_ff_01");
    one8(8'h00, 8'h80, 1'b1, 4'h5, 16'h0000, "s_00_80");

    // Back-pressure: five back-to-back ops, output stalled for 4 cycles.
    seq = n_out8;
    fork
      begin
        send8(8'h03, 8'h05, 1'b0, 4'h1);
        send8(8'hF6, 8'h07, 1'b1, 4'h2);
        send8(8'hC8, 8'h9C, 1'b0, 4'h3);
        send8(8'h81, 8'h7F, 1'b1, 4'h4);
        send8(8'h10, 8'h10, 1'b0, 4'h5);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    k = 0;
    while (n_out8 < seq + 5 && k < 50) begin @(negedge clk); k++; end
    chk("bp_count", n_out8 - seq, 32'd5);
    @(posedge clk); #1;

    // Reset while two ops are in flight.
    send8(8'h11, 8'h22, 1'b0, 4'h6);
    send8(8'h33, 8'h44, 1'b1, 4'h7);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // WIDTH=4 latency and literals.
    u4_in_a = 4'hF; u4_in_b = 4'hF; u4_in_signed = 1'b0; u4_in_tag = 4'h9; u4_in_valid = 1'b1;
    @(posedge clk); #1;
    u4_in_a = 4'h8; u4_in_b = 4'h8; u4_in_signed = 1'b1; u4_in_tag = 4'h8;
    @(negedge clk); chk("w4_lat_c1", 32'(u4_out_valid), 32'd0);
    @(posedge clk); #1;
    u4_in_valid = 1'b0;
    @(negedge clk); chk("w4_lat_c2", 32'(u4_out_valid), 32'd1);
    chk("w4_f_f", 32'(u4_out_p), 32'h0000_00E1);
    @(negedge clk); chk("w4_s_8_8", 32'(u4_out_p), 32'h0000_0040);
    @(posedge clk); #1;

    // WIDTH=4 exhaustive sweep with random valid and ready.
    seq = 0;
    n_out4 = 0;
    fork
      begin
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            for (int s = 0; s < 2; s++) begin
              u4_in_a = 4'(a); u4_in_b = 4'(b); u4_in_signed = 1'(s); u4_in_tag = 4'(seq);
              seq++;
              acc = 1'b0; k = 0;
              while (!acc && k < 200) begin
                u4_in_valid = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = u4_in_valid && u4_in_ready;
                @(posedge clk); #1;
                k++;
              end
              if (!acc) chk("w4_send_timeout", 32'(acc), 32'd1);
            end
          end
        end
        u4_in_valid = 1'b0;
        w4_done = 1'b1;
      end
      begin
        while (!w4_done) begin
          @(posedge clk); #1;
          u4_out_ready = ($urandom_range(0, 2) != 0);
        end
        u4_out_ready = 1'b1;
      end
    join
    k = 0;
    while (q4.size() != 0 && k < 50) begin @(negedge clk); k++; end
    chk("w4_drained", 32'(q4.size()), 32'd0);
    chk("w4_count", n_out4, 32'd512);
    chk("w8_drained", 32'(q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
